// File: rtl/serial_operand_loader.sv
// Bit-serial loader feeding the equality unit: assembles x then y from one serial
// stream and presents the pair in parallel behind a valid/ready handshake.
module serial_operand_loader #(
   parameter int WIDTH     = 6,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             out_ready,
   input  logic             clear_err,
   output logic             busy,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y, HOLD} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sx;
   logic [WIDTH-1:0] sy;
   logic             bad_start;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b);
      if (MSB_FIRST)
         return {r[WIDTH-2:0], b};
      else
         return {b, r[WIDTH-1:1]};
   endfunction

   // A start the FSM cannot honour: mid-load, or in HOLD before the consumer takes the pair.
   assign bad_start = start && ((state == LOAD_X) || (state == LOAD_Y) ||
                                ((state == HOLD) && !out_ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sx        <= '0;
         sy        <= '0;
         x         <= '0;
         y         <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (bad_start)
            err <= 1'b1;
         else if (clear_err)
            err <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state <= LOAD_X;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            LOAD_X: begin
               if (sin_valid) begin
                  sx <= shift_in(sx, sin);
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= LOAD_Y;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            LOAD_Y: begin
               if (sin_valid) begin
                  sy <= shift_in(sy, sin);
                  if (cnt == LAST) begin
                     // Output registers take the final y including the bit sampled right now.
                     cnt       <= '0;
                     x         <= sx;
                     y         <= shift_in(sy, sin);
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     state <= LOAD_X;
                     cnt   <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_operand_loader.sv
// Scoreboard bench: one MSB-first and one LSB-first loader share all stimulus;
// expected pairs are queued per instance and checked at each handshake.
module tb_serial_operand_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, sin, sin_valid, out_ready, clear_err;
   logic       busy_m, out_valid_m, err_m;
   logic [5:0] x_m, y_m;
   logic       busy_l, out_valid_l, err_l;
   logic [5:0] x_l, y_l;

   int errors = 0;
   int checks = 0;
   logic [11:0] exp_m[$];
   logic [11:0] exp_l[$];

   always #5 clk = ~clk;

   serial_operand_loader #(.WIDTH(6), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_valid(sin_valid),
      .out_ready(out_ready), .clear_err(clear_err), .busy(busy_m), .x(x_m), .y(y_m),
      .out_valid(out_valid_m), .err(err_m));

   serial_operand_loader #(.WIDTH(6), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .start(start), .sin(sin), .sin_valid(sin_valid),
      .out_ready(out_ready), .clear_err(clear_err), .busy(busy_l), .x(x_l), .y(y_l),
      .out_valid(out_valid_l), .err(err_l));

   function automatic logic [5:0] rev6(input logic [5:0] v);
      logic [5:0] r;
      for (int i = 0; i < 6; i++) r[i] = v[5-i];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle worth of inputs, then return just after the sampling edge.
   task automatic applyStimulus(input logic st, input logic b, input logic bv,
                                input logic rdy, input logic clr);
      start = st; sin = b; sin_valid = bv; out_ready = rdy; clear_err = clr;
      @(posedge clk);
      #1;
      start = 1'b0; sin_valid = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
   endtask

   task automatic startPulse();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Stream x then y MSB-of-value first; the LSB-first instance therefore sees them reversed.
   task automatic sendPair(input logic [5:0] xv, input logic [5:0] yv, input int gap,
                           input int start_before);
      logic [11:0] stream;
      stream = {xv, yv};
      exp_m.push_back({xv, yv});
      exp_l.push_back({rev6(xv), rev6(yv)});
      for (int i = 0; i < 12; i++) begin
         if (i == start_before) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("err_mid_load", {31'd0, err_m}, 32'd1);
         end
         if (i == 11) checkOutput("no_early_valid", {31'd0, out_valid_m}, 32'd0);
         applyStimulus(1'b0, stream[11-i], 1'b1, 1'b0, 1'b0);
         for (int g = 0; g < gap; g++) begin
            applyStimulus(1'b0, ~stream[11-i], 1'b0, 1'b0, 1'b0);
            if (i == 11) checkOutput("valid_in_gap", {31'd0, out_valid_m}, 32'd1);
         end
      end
      checkOutput("valid_after_12", {31'd0, out_valid_m}, 32'd1);
      checkOutput("busy_in_hold", {31'd0, busy_m}, 32'd1);
   endtask

   task automatic handshake();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("idle_valid", {31'd0, out_valid_m}, 32'd0);
      checkOutput("idle_busy", {31'd0, busy_m}, 32'd0);
   endtask

   // Monitor: every accepted pair is compared against the head of its instance's queue.
   always @(negedge clk) begin
      if (rst_n && out_ready && out_valid_m) begin
         checks++;
         if (exp_m.size() == 0) begin
            errors++;
            $display("[TB] FAIL pair_m: got %b_%b expected none", x_m, y_m);
         end else if ({x_m, y_m} !== exp_m[0]) begin
            errors++;
            $display("[TB] FAIL pair_m: got %b_%b expected %b_%b", x_m, y_m,
                     exp_m[0][11:6], exp_m[0][5:0]);
            void'(exp_m.pop_front());
         end else begin
            void'(exp_m.pop_front());
         end
      end
      if (rst_n && out_ready && out_valid_l) begin
         checks++;
         if (exp_l.size() == 0) begin
            errors++;
            $display("[TB] FAIL pair_l: got %b_%b expected none", x_l, y_l);
         end else if ({x_l, y_l} !== exp_l[0]) begin
            errors++;
            $display("[TB] FAIL pair_l: got %b_%b expected %b_%b", x_l, y_l,
                     exp_l[0][11:6], exp_l[0][5:0]);
            void'(exp_l.pop_front());
         end else begin
            void'(exp_l.pop_front());
         end
      end
   end

   initial begin
      rst_n = 1'b0; start = 0; sin = 0; sin_valid = 0; out_ready = 0; clear_err = 0;
      #2;
      checkOutput("rst_busy", {31'd0, busy_m}, 32'd0);
      checkOutput("rst_valid", {31'd0, out_valid_m}, 32'd0);
      checkOutput("rst_xy", {20'd0, x_m, y_m}, 32'd0);
      checkOutput("rst_err", {31'd0, err_m}, 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic MSB-first load, then release the pair.
      startPulse();
      checkOutput("busy_after_start", {31'd0, busy_m}, 32'd1);
      sendPair(6'b101101, 6'b101101, 0, -1);
      handshake();

      // Three idle cycles between serial bits; sin_valid=1 in IDLE must not be consumed.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("idle_sin_ignored", {31'd0, busy_m}, 32'd0);
      startPulse();
      sendPair(6'b000111, 6'b111000, 3, -1);
      handshake();

      // Backpressure with sin toggling in HOLD.
      startPulse();
      sendPair(6'b110010, 6'b001101, 0, -1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, i[0], 1'b1, 1'b0, 1'b0);
         checkOutput("hold_valid", {31'd0, out_valid_m}, 32'd1);
         checkOutput("hold_xy_m", {20'd0, x_m, y_m}, {20'd0, 12'b110010_001101});
         checkOutput("hold_xy_l", {20'd0, x_l, y_l}, {20'd0, rev6(6'b110010), rev6(6'b001101)});
      end
      handshake();

      // Stray start after 3 y bits; load still completes; then clear, then set+clear.
      startPulse();
      sendPair(6'b011011, 6'b100101, 0, 9);
      handshake();
      checkOutput("err_sticky", {31'd0, err_m}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("err_cleared", {31'd0, err_m}, 32'd0);
      startPulse();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("err_set_wins", {31'd0, err_m}, 32'd1);
      sendPair(6'b111111, 6'b000001, 0, -1);
      handshake();

      // Asynchronous reset mid-load, then a fresh unequal pair.
      startPulse();
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_busy", {31'd0, busy_m}, 32'd0);
      checkOutput("arst_xy", {20'd0, x_m, y_m}, 32'd0);
      checkOutput("arst_err", {31'd0, err_m}, 32'd0);
      checkOutput("arst_valid", {31'd0, out_valid_m}, 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      startPulse();
      sendPair(6'b010101, 6'b010100, 0, -1);
      checkOutput("cmp_s", {31'd0, (x_m == y_m)}, 32'd0);
      handshake();

      // Back-to-back: handshake and start in the same HOLD cycle.
      startPulse();
      sendPair(6'b100110, 6'b011001, 0, -1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("b2b_valid", {31'd0, out_valid_m}, 32'd0);
      checkOutput("b2b_busy", {31'd0, busy_m}, 32'd1);
      checkOutput("b2b_err", {31'd0, err_m}, 32'd0);
      sendPair(6'b111100, 6'b000011, 0, -1);
      handshake();

      checkOutput("queue_m_empty", exp_m.size(), 32'd0);
      checkOutput("queue_l_empty", exp_l.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
